// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and helpers for the AXI read-port arbiter (axi_rd_arbiter).
// Optional watchdog in the top level is enabled with AXI_RD_ARB_WDOG_EN.
package axi_rd_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        exokay;
    } rd_arb_rsp_t;

    // Index width for a requester count; a single bit even for degenerate sizes.
    function automatic int arb_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int rr_wrap(input int val, input int n);
        return (val >= n) ? (val - n) : val;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i.
module axi_rd_arbiter_rr
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdxW   = 1
) (
    input  logic [NumReq-1:0] elig_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdxW'(rr_wrap(int'(ptr_i) + k, NumReq));
            if (!valid_o && elig_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-port arbiter sharing one axi_shim AR/R channel among NumReq refill requesters.
// Define AXI_RD_ARB_WDOG_EN to add the stalled-read watchdog driving err_o.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | arbitrate each cycle from rr_ptr, AR driven from the pick
// HOLD    | AR presented but not accepted, fields frozen on sel_q
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int          NumReq         = 2,
    parameter int          AxiIdWidth     = 4,
    parameter int          AxiNumWords    = 4,
    parameter int          MaxOutstanding = 2,
    parameter int unsigned WdogCycles     = 1024,
    localparam int         IdxW           = arb_idx_w(NumReq),
    localparam int         LocIdW         = AxiIdWidth - IdxW,
    localparam int         BLW            = ($clog2(AxiNumWords) > 0) ? $clog2(AxiNumWords) : 1,
    localparam int         CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,

    input  logic [NumReq-1:0]                req_rd_req_i,
    output logic [NumReq-1:0]                req_rd_gnt_o,
    input  logic [NumReq-1:0][63:0]          req_rd_addr_i,
    input  logic [NumReq-1:0][BLW-1:0]       req_rd_blen_i,
    input  logic [NumReq-1:0][1:0]           req_rd_size_i,
    input  logic [NumReq-1:0][LocIdW-1:0]    req_rd_id_i,
    input  logic [NumReq-1:0]                req_rd_rdy_i,
    output logic [NumReq-1:0]                req_rd_valid_o,
    output logic                             req_rd_last_o,
    output logic [63:0]                      req_rd_data_o,
    output logic [LocIdW-1:0]                req_rd_id_o,
    output logic                             req_rd_exokay_o,

    output logic                             rd_req_o,
    input  logic                             rd_gnt_i,
    output logic [63:0]                      rd_addr_o,
    output logic [BLW-1:0]                   rd_blen_o,
    output logic [1:0]                       rd_size_o,
    output logic [AxiIdWidth-1:0]            rd_id_o,
    output logic                             rd_lock_o,

    output logic                             rd_rdy_o,
    input  logic                             rd_valid_i,
    input  logic                             rd_last_i,
    input  logic [63:0]                      rd_data_i,
    input  logic [AxiIdWidth-1:0]            rd_id_i,
    input  logic                             rd_exokay_i,

    output logic                             err_o
);

    typedef struct packed {
        logic [63:0]       addr;
        logic [BLW-1:0]    blen;
        logic [1:0]        size;
        logic [LocIdW-1:0] id;
    } rd_arb_req_t;

    logic [0:0]                   state_q, state_d;
    logic [IdxW-1:0]              sel_q, sel_d;
    logic [IdxW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NumReq-1:0][CntW-1:0]  outst_q, outst_d;

    logic [NumReq-1:0]            elig;
    logic [IdxW-1:0]              pick_idx;
    logic                         pick_valid;
    logic [IdxW-1:0]              ar_idx;
    logic                         ar_valid;
    logic                         gnt_fire;
    rd_arb_req_t                  ar_sel;

    logic [IdxW-1:0]              owner;
    logic                         owner_ok;
    logic                         r_hs;
    logic                         r_last_hs;
    logic [NumReq-1:0]            cnt_inc;
    logic [NumReq-1:0]            cnt_dec;
    rd_arb_rsp_t                  rsp;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            elig[i] = req_rd_req_i[i] && (outst_q[i] < CntW'(MaxOutstanding));
        end
    end

    axi_rd_arbiter_rr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) i_rr (
        .elig_i  (elig),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // HOLD freezes the AR channel on the latched owner until the shim accepts it.
    always_comb begin
        ar_valid = (state_q == ST_HOLD) ? 1'b1  : pick_valid;
        ar_idx   = (state_q == ST_HOLD) ? sel_q : pick_idx;
    end

    assign gnt_fire = ar_valid && rd_gnt_i;

    always_comb begin
        ar_sel = '0;
        if (ar_valid) begin
            ar_sel.addr = req_rd_addr_i[ar_idx];
            ar_sel.blen = req_rd_blen_i[ar_idx];
            ar_sel.size = req_rd_size_i[ar_idx];
            ar_sel.id   = req_rd_id_i[ar_idx];
        end
    end

    assign rd_req_o  = ar_valid;
    assign rd_addr_o = ar_sel.addr;
    assign rd_blen_o = ar_sel.blen;
    assign rd_size_o = ar_sel.size;
    assign rd_id_o   = {(ar_valid ? ar_idx : IdxW'(0)), ar_sel.id};
    assign rd_lock_o = 1'b0;

    always_comb begin
        req_rd_gnt_o = '0;
        if (gnt_fire) begin
            req_rd_gnt_o[ar_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt_fire) begin
            state_d  = ST_IDLE;
            rr_ptr_d = IdxW'(rr_wrap(int'(ar_idx) + 1, NumReq));
        end else if ((state_q == ST_IDLE) && pick_valid) begin
            state_d = ST_HOLD;
            sel_d   = pick_idx;
        end
    end

    assign owner = rd_id_i[AxiIdWidth-1 -: IdxW];

    generate
        if ((1 << IdxW) == NumReq) begin : g_owner_full
            assign owner_ok = 1'b1;
        end else begin : g_owner_chk
            assign owner_ok = (int'(owner) < NumReq);
        end
    endgenerate

    // Beats for a non-existent owner are swallowed so the shim never stalls on them.
    always_comb begin
        req_rd_valid_o = '0;
        rd_rdy_o       = 1'b1;
        if (owner_ok) begin
            req_rd_valid_o[owner] = rd_valid_i;
            rd_rdy_o              = req_rd_rdy_i[owner];
        end
    end

    assign rsp             = '{data: rd_data_i, last: rd_last_i, exokay: rd_exokay_i};
    assign req_rd_data_o   = rsp.data;
    assign req_rd_last_o   = rsp.last;
    assign req_rd_exokay_o = rsp.exokay;
    assign req_rd_id_o     = rd_id_i[LocIdW-1:0];

    assign r_hs      = rd_valid_i && rd_rdy_o;
    assign r_last_hs = r_hs && rd_last_i && owner_ok;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            cnt_inc[i] = gnt_fire  && (ar_idx == IdxW'(i));
            cnt_dec[i] = r_last_hs && (owner  == IdxW'(i));
        end
    end

    // Decrement saturates so stale last beats after a clear cannot wrap a counter.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            outst_d[i] = outst_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                outst_d[i] = outst_q[i] + CntW'(1);
            end else if (cnt_dec[i] && !cnt_inc[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            outst_q  <= '0;
        end else if (clr_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            outst_q  <= outst_d;
        end
    end

`ifdef AXI_RD_ARB_WDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        err_q, err_d;
    logic        any_outst;

    assign any_outst = |outst_q;

    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        if (r_hs || !any_outst) begin
            wdog_d = '0;
        end else if (wdog_q != 32'hFFFF_FFFF) begin
            wdog_d = wdog_q + 32'd1;
        end
        if (wdog_d == WdogCycles) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else if (clr_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
